wm_setup_ctrl: RTL

//  Parametrised pre-wash setup controller for the washing machine. Three phases:
//   - balance entry: DIGITS BCD digits plus a sign.
//   - mode selection: N_MODES modes.
//   - wash-time entry: two BCD digits, checked against the balance.

---
 rtl/wm_setup_ctrl_pkg.sv | 19 +
 rtl/wm_setup_ctrl_btn_edge.sv | 25 ++
 rtl/wm_setup_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wm_setup_ctrl_pkg.sv
// Shared types and constants for the washing-machine setup controller.
// State encodings, display nibble codes and a wrapping BCD digit increment.
package wm_setup_ctrl_pkg;

  typedef enum logic [1:0] {
    S_BAL   = 2'd0,
    S_MODE  = 2'd1,
    S_TIME  = 2'd2,
    S_READY = 2'd3
  } state_t;

  localparam logic [3:0] NIB_OFF = 4'hB;
  localparam logic [3:0] NIB_NEG = 4'hA;

  function automatic logic [3:0] nib_wrap_inc(input logic [3:0] d, input logic [3:0] top);
    return (d >= top) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/wm_setup_ctrl_btn_edge.sv
// Raw push-button conditioning: 2-FF synchroniser followed by a rising-edge detector.
// The rise pulse is combinational, so an action lands on the third clock edge after the raw edge.
module wm_setup_ctrl_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic din,
  output logic rise
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh <= '0;
    end else if (clr) begin
      sh <= '0;
    end else begin
      sh <= {sh[1:0], din};
    end
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/wm_setup_ctrl.sv
// Pre-wash setup controller: balance entry, mode selection and wash-time entry,
// raising ready once a legal and affordable job has been confirmed.
//
//   state   | meaning
//   S_BAL   | enter signed BCD balance with tick-driven digit increments
//   S_MODE  | cycle the mode index with inc, confirm with next
//   S_TIME  | enter two-digit wash time, confirm against range and balance
//   S_READY | job accepted; waits for rst or on=0
module wm_setup_ctrl
  import wm_setup_ctrl_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int N_MODES  = 4,
  parameter int TICK_DIV = 66000000,
  parameter int MAX_TIME = 20,
  parameter int PRICE    = 1,
  parameter int BAL_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       on,
  input  logic [DIGITS-1:0]          sw,
  input  logic                       sign_sw,
  input  logic                       btn_inc,
  input  logic                       btn_next,
  output logic [15:0]                disp_r,
  output logic [15:0]                disp_l,
  output logic [BAL_W-1:0]           bal,
  output logic [$clog2(N_MODES)-1:0] mode,
  output logic [6:0]                 wash_time,
  output logic                       ready,
  output logic                       err,
  output logic [2:0]                 st_light
);

  localparam int MW = $clog2(N_MODES);
  localparam int TW = $clog2(TICK_DIV + 1);

  state_t            state, state_nx;
  logic [2:0][3:0]   dig, dig_nx;
  logic              neg, neg_nx;
  logic [MW-1:0]     idx, idx_nx;
  logic [3:0]        t1, t1_nx, t0, t0_nx;
  logic [BAL_W-1:0]  bal_q, bal_nx;
  logic [MW-1:0]     mode_q, mode_nx;
  logic [6:0]        wt_q, wt_nx;
  logic              err_q, err_nx;
  logic [TW-1:0]     tick_cnt;
  logic              tick, inc_rise, nxt_rise;
  logic [2:0]        sw_pad;
  logic [BAL_W+3:0]  bcd_val;
  logic [6:0]        t_val;
  logic [BAL_W+6:0]  cost;
  logic [2:0][3:0]   d_show;

  wm_setup_ctrl_btn_edge u_inc (.clk(clk), .rst(rst), .clr(~on), .din(btn_inc),  .rise(inc_rise));
  wm_setup_ctrl_btn_edge u_nxt (.clk(clk), .rst(rst), .clr(~on), .din(btn_next), .rise(nxt_rise));

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (!on || (state_nx != state) || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_comb begin
    sw_pad = '0;
    sw_pad[DIGITS-1:0] = sw;
    bcd_val = (BAL_W+4)'(dig[2]) * (BAL_W+4)'(100) + (BAL_W+4)'(dig[1]) * (BAL_W+4)'(10)
            + (BAL_W+4)'(dig[0]);
    t_val   = 7'(t1) * 7'd10 + 7'(t0);
    cost    = (BAL_W+7)'(t_val) * (BAL_W+7)'(PRICE);
  end

  always_comb begin
    state_nx = state;
    dig_nx   = dig;
    neg_nx   = neg;
    idx_nx   = idx;
    t1_nx    = t1;
    t0_nx    = t0;
    bal_nx   = bal_q;
    mode_nx  = mode_q;
    wt_nx    = wt_q;
    err_nx   = 1'b0;
    case (state)
      S_BAL: begin
        if (nxt_rise) begin
          dig_nx = '0;
          if (sw_pad == 3'd0 && !sign_sw && !neg) begin
            bal_nx   = BAL_W'(bcd_val);
            state_nx = S_MODE;
          end else begin
            neg_nx = 1'b0;
            err_nx = 1'b1;
          end
        end else if (tick) begin
          for (int i = 0; i < 3; i++) begin
            if (sw_pad[i]) dig_nx[i] = nib_wrap_inc(dig[i], 4'd9);
          end
          if (sign_sw) neg_nx = ~neg;
        end
      end
      S_MODE: begin
        if (nxt_rise) begin
          mode_nx  = idx;
          state_nx = S_TIME;
        end else if (inc_rise) begin
          idx_nx = (idx == MW'(N_MODES - 1)) ? '0 : idx + MW'(1);
        end
      end
      S_TIME: begin
        if (nxt_rise) begin
          if (t_val >= 7'd1 && t_val <= 7'(MAX_TIME) && cost <= (BAL_W+7)'(bal_q)) begin
            wt_nx    = t_val;
            bal_nx   = bal_q - BAL_W'(cost);
            state_nx = S_READY;
          end else begin
            t1_nx  = 4'd0;
            t0_nx  = 4'd0;
            err_nx = 1'b1;
          end
        end else if (inc_rise) begin
          if (sw_pad[0]) t1_nx = nib_wrap_inc(t1, 4'(MAX_TIME / 10));
          else           t0_nx = nib_wrap_inc(t0, 4'd9);
        end
      end
      default: ;
    endcase
    // on=0 holds the whole setup in its reset state
    if (!on) begin
      state_nx = S_BAL;
      dig_nx   = '0;
      neg_nx   = 1'b0;
      idx_nx   = '0;
      t1_nx    = 4'd0;
      t0_nx    = 4'd0;
      bal_nx   = '0;
      mode_nx  = '0;
      wt_nx    = '0;
      err_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_BAL;
      dig    <= '0;
      neg    <= 1'b0;
      idx    <= '0;
      t1     <= 4'd0;
      t0     <= 4'd0;
      bal_q  <= '0;
      mode_q <= '0;
      wt_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      dig    <= dig_nx;
      neg    <= neg_nx;
      idx    <= idx_nx;
      t1     <= t1_nx;
      t0     <= t0_nx;
      bal_q  <= bal_nx;
      mode_q <= mode_nx;
      wt_q   <= wt_nx;
      err_q  <= err_nx;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) d_show[i] = (i < DIGITS) ? dig[i] : NIB_OFF;
    disp_r   = {4{NIB_OFF}};
    disp_l   = {4{NIB_OFF}};
    st_light = 3'b001;
    case (state)
      S_BAL:   disp_r = {(neg ? NIB_NEG : 4'h0), d_show[2], d_show[1], d_show[0]};
      S_MODE: begin
        disp_r   = {NIB_OFF, NIB_OFF, NIB_OFF, 4'(idx)};
        st_light = 3'b010;
      end
      S_TIME: begin
        disp_l   = {4'(mode_q), NIB_OFF, t1, t0};
        st_light = 3'b100;
      end
      default: begin
        disp_l   = {4'(mode_q), NIB_OFF, t1, t0};
        st_light = 3'b111;
      end
    endcase
  end

  assign bal       = bal_q;
  assign mode      = mode_q;
  assign wash_time = wt_q;
  assign ready     = (state == S_READY);
  assign err       = err_q;

endmodule
